ifetch_unit: RTL and testbench

Instruction fetch front end for the myCPU core. Owns the program counter, issues word reads to instruction memory, and buffers returned instruction words with their PCs in a 2-entry queue that the opcode decoder drains through a valid/ready handshake. Execute-stage redirects (taken branch, JAL, JALR) flush the queue, discard any in-flight read, and restart fetch at the new target.

---
 rtl/ifetch_unit.sv | 130 +++++++++++++
 tb/tb_ifetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one word read at a time
// and buffers returned instructions in a 2-entry queue for the decoder.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_pc_d;
  logic [31:0] e0_instr_q, e0_instr_d;
  logic [31:0] e1_pc_q, e1_pc_d;
  logic [31:0] e1_instr_q, e1_instr_d;

  logic req_fire;
  logic push;
  logic pop;
  logic push_to_e0;

  // Requests only from S_REQ with queue room, so count plus outstanding stays <= 2.
  assign imem_req_valid = (state_q == S_REQ) && (count_q < 2'd2);
  assign imem_addr      = pc_q;
  assign instr_valid    = (count_q != 2'd0);
  assign instr          = e0_instr_q;
  assign instr_pc       = e0_pc_q;

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign push       = (state_q == S_WAIT) && imem_rsp_valid;
  assign pop        = instr_valid && instr_ready;
  assign push_to_e0 = (count_q == 2'd0) || ((count_q == 2'd1) && pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    e0_pc_d    = e0_pc_q;
    e0_instr_d = e0_instr_q;
    e1_pc_d    = e1_pc_q;
    e1_instr_d = e1_instr_q;

    if (redirect_valid) begin
      // Redirect wins: empty the queue and remember whether a stale read must be absorbed.
      pc_d    = redirect_target & 32'hFFFF_FFFC;
      count_d = 2'd0;
      case (state_q)
        S_REQ:   state_d = req_fire ? S_FLUSH : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
        S_FLUSH: state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        S_FLUSH: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (pop) begin
        e0_pc_d    = e1_pc_q;
        e0_instr_d = e1_instr_q;
      end
      if (push) begin
        if (push_to_e0) begin
          e0_pc_d    = req_pc_q;
          e0_instr_d = imem_rdata;
        end else begin
          e1_pc_d    = req_pc_q;
          e1_instr_d = imem_rdata;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      count_q    <= 2'd0;
      e0_pc_q    <= 32'd0;
      e0_instr_q <= 32'd0;
      e1_pc_q    <= 32'd0;
      e1_instr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      e0_pc_q    <= e0_pc_d;
      e0_instr_q <= e0_instr_d;
      e1_pc_q    <= e1_pc_d;
      e1_instr_q <= e1_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a latency-programmable memory plus a stream-level model
// of the expected fetch and delivery PC sequences.
module tb_ifetch_unit;

  localparam logic [31:0] KEY        = 32'hA5A5_0000;
  localparam logic [31:0] A_RESET_PC = 32'h0000_0100;
  localparam logic [31:0] B_RESET_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_ready, rsp_valid, redir_valid, iready;
  logic [31:0] rdata, redir_target;
  logic        req_valid, ivalid;
  logic [31:0] addr, instr, instr_pc;

  logic        b_reset, b_rsp_valid, b_req_valid, b_ivalid;
  logic [31:0] b_rdata, b_addr, b_instr, b_instr_pc;

  ifetch_unit #(.RESET_PC(A_RESET_PC)) dut_a (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rdata(rdata),
    .redirect_valid(redir_valid), .redirect_target(redir_target),
    .instr_valid(ivalid), .instr_ready(iready), .instr(instr), .instr_pc(instr_pc)
  );

  ifetch_unit #(.RESET_PC(B_RESET_PC)) dut_b (
    .clk(clk), .reset(b_reset),
    .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_addr(b_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rdata(b_rdata),
    .redirect_valid(1'b0), .redirect_target(32'd0),
    .instr_valid(b_ivalid), .instr_ready(1'b1), .instr(b_instr), .instr_pc(b_instr_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc;
  logic [31:0] mem_q[$];
  int          mem_due[$];
  int          pop_cyc[$];
  logic [31:0] exp_fetch, exp_deliver;
  logic        prev_redir, prev_stall;
  logic [31:0] prev_addr;
  int          n_accepts, n_pops, first_acc_cyc;
  int          cfg_ready_pct, cfg_iready_pct, cfg_redir_pct, cfg_lat_min, cfg_lat_max;
  logic        force_redir;
  logic [31:0] force_target;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic setCfg(input int rdy, input int ird, input int rdr, input int lmin, input int lmax);
    cfg_ready_pct  = rdy;
    cfg_iready_pct = ird;
    cfg_redir_pct  = rdr;
    cfg_lat_min    = lmin;
    cfg_lat_max    = lmax;
  endtask

  // Called at a negedge; holds reset for one edge and checks the reset-state outputs.
  task automatic doReset();
    reset        = 1'b1;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rdata        = 32'd0;
    redir_valid  = 1'b0;
    redir_target = 32'd0;
    iready       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", 32'(req_valid), 32'd1);
    checkOutput("rst_addr", addr, A_RESET_PC);
    checkOutput("rst_instr_valid", 32'(ivalid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    reset = 1'b0;
    mem_q.delete();
    mem_due.delete();
    pop_cyc.delete();
    exp_fetch     = A_RESET_PC;
    exp_deliver   = A_RESET_PC;
    cyc           = 0;
    prev_redir    = 1'b0;
    prev_stall    = 1'b0;
    prev_addr     = 32'd0;
    n_accepts     = 0;
    n_pops        = 0;
    first_acc_cyc = -1;
    force_redir   = 1'b0;
  endtask

  // One call per cycle: drive inputs at the negedge, score the handshakes they imply.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      logic        busy;
      logic [31:0] tgt;
      int          lat;
      if (prev_redir) checkOutput("flush_clears_valid", 32'(ivalid), 32'd0);
      if (prev_stall) begin
        checkOutput("req_hold_valid", 32'(req_valid), 32'd1);
        checkOutput("req_hold_addr", addr, prev_addr);
      end

      busy      = (mem_q.size() != 0);
      rsp_valid = 1'b0;
      rdata     = 32'd0;
      if (busy && cyc >= mem_due[0]) begin
        rsp_valid = 1'b1;
        rdata     = mem_q[0] ^ KEY;
        void'(mem_q.pop_front());
        void'(mem_due.pop_front());
      end

      req_ready    = (int'($urandom_range(99, 0)) < cfg_ready_pct);
      iready       = (int'($urandom_range(99, 0)) < cfg_iready_pct);
      redir_valid  = force_redir || (int'($urandom_range(99, 0)) < cfg_redir_pct);
      tgt          = force_redir ? force_target : $urandom();
      redir_target = tgt;
      force_redir  = 1'b0;

      if (req_valid && req_ready) begin
        checkOutput("one_outstanding", 32'(busy), 32'd0);
        checkOutput("fetch_addr", addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        lat = int'($urandom_range(cfg_lat_max, cfg_lat_min));
        mem_q.push_back(addr);
        mem_due.push_back(cyc + lat);
        n_accepts++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (ivalid && iready) begin
        checkOutput("instr_pc", instr_pc, exp_deliver);
        checkOutput("instr_word", instr, exp_deliver ^ KEY);
        exp_deliver = exp_deliver + 32'd4;
        n_pops++;
        pop_cyc.push_back(cyc);
      end
      if (redir_valid) begin
        exp_fetch   = {tgt[31:2], 2'b00};
        exp_deliver = {tgt[31:2], 2'b00};
      end

      prev_redir = redir_valid;
      prev_stall = req_valid && !req_ready && !redir_valid;
      prev_addr  = addr;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] b_addrs[$];
    logic        b_pend, b_got;
    logic [31:0] b_last_addr, b_first_pc, b_first_instr, hold_addr;

    reset = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rdata = 32'd0;
    redir_valid = 1'b0; redir_target = 32'd0; iready = 1'b0;
    cyc = 0; force_redir = 1'b0; force_target = 32'd0;
    setCfg(100, 100, 0, 1, 1);

    // Wrap-around fetch on the second instance with a 1-cycle memory.
    b_reset = 1'b1; b_rsp_valid = 1'b0; b_rdata = 32'd0;
    b_pend = 1'b0; b_got = 1'b0; b_last_addr = 32'd0;
    b_first_pc = 32'd0; b_first_instr = 32'd0;
    @(posedge clk);
    @(negedge clk);
    b_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_rsp_valid = b_pend;
      b_rdata     = b_last_addr ^ KEY;
      b_pend      = b_req_valid;
      if (b_req_valid) begin
        b_addrs.push_back(b_addr);
        b_last_addr = b_addr;
      end
      if (b_ivalid && !b_got) begin
        b_got         = 1'b1;
        b_first_pc    = b_instr_pc;
        b_first_instr = b_instr;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("wrap_nreq", 32'(b_addrs.size() >= 3), 32'd1);
    if (b_addrs.size() >= 3) begin
      checkOutput("wrap_addr0", b_addrs[0], 32'hFFFF_FFF8);
      checkOutput("wrap_addr1", b_addrs[1], 32'hFFFF_FFFC);
      checkOutput("wrap_addr2", b_addrs[2], 32'h0000_0000);
    end
    checkOutput("wrap_got", 32'(b_got), 32'd1);
    checkOutput("wrap_first_pc", b_first_pc, 32'hFFFF_FFF8);
    checkOutput("wrap_first_instr", b_first_instr, 32'hFFFF_FFF8 ^ KEY);

    // Streaming at one instruction per two cycles.
    $display("[TB] streaming with 1-cycle memory");
    doReset();
    setCfg(100, 100, 0, 1, 1);
    applyStimulus(8);
    checkOutput("t1_first_acc", 32'(first_acc_cyc), 32'd0);
    checkOutput("t1_npops", 32'(pop_cyc.size() >= 3), 32'd1);
    if (pop_cyc.size() >= 3) begin
      checkOutput("t1_pop0_cyc", 32'(pop_cyc[0]), 32'd2);
      checkOutput("t1_pop1_cyc", 32'(pop_cyc[1]), 32'd4);
      checkOutput("t1_pop2_cyc", 32'(pop_cyc[2]), 32'd6);
    end

    // Decoder stalled: queue fills to two, then fetch stops until a pop.
    $display("[TB] full queue backpressure");
    doReset();
    setCfg(100, 0, 0, 1, 1);
    applyStimulus(12);
    checkOutput("t2_accepts", 32'(n_accepts), 32'd2);
    checkOutput("t2_req_blocked", 32'(req_valid), 32'd0);
    checkOutput("t2_head_valid", 32'(ivalid), 32'd1);
    checkOutput("t2_head_pc", instr_pc, 32'h0000_0100);
    setCfg(100, 100, 0, 1, 1);
    applyStimulus(1);
    checkOutput("t2_req_after_pop", 32'(req_valid), 32'd1);
    checkOutput("t2_addr_after_pop", addr, 32'h0000_0108);
    applyStimulus(10);
    checkOutput("t2_pops", 32'(n_pops >= 3), 32'd1);

    // Redirect while a 3-cycle read is outstanding.
    $display("[TB] redirect with read outstanding");
    doReset();
    setCfg(100, 100, 0, 3, 3);
    applyStimulus(1);
    force_redir  = 1'b1;
    force_target = 32'h0000_2002;
    applyStimulus(1);
    checkOutput("t3_stale_block0", 32'(req_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t3_stale_block1", 32'(req_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t3_req_target_v", 32'(req_valid), 32'd1);
    checkOutput("t3_req_target", addr, 32'h0000_2000);
    applyStimulus(10);
    checkOutput("t3_delivered", 32'(n_pops >= 1), 32'd1);

    // Redirect in the same cycle as a response and a decoder pop.
    $display("[TB] redirect with response and pop");
    doReset();
    setCfg(100, 0, 0, 1, 1);
    applyStimulus(3);
    checkOutput("t4_setup_valid", 32'(ivalid), 32'd1);
    checkOutput("t4_setup_pc", instr_pc, 32'h0000_0100);
    setCfg(100, 100, 0, 1, 1);
    force_redir  = 1'b1;
    force_target = 32'h0000_3000;
    applyStimulus(1);
    checkOutput("t4_req_v", 32'(req_valid), 32'd1);
    checkOutput("t4_req_addr", addr, 32'h0000_3000);
    applyStimulus(8);

    // Memory stall holds the address; reset mid-stream restarts fetch.
    $display("[TB] memory stall then reset");
    doReset();
    setCfg(0, 100, 0, 1, 1);
    hold_addr = addr;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("t6_addr_hold", addr, hold_addr);
    end
    doReset();
    setCfg(100, 100, 0, 1, 1);
    applyStimulus(6);
    checkOutput("t6_restart", 32'(n_pops >= 1), 32'd1);

    // Randomized traffic with occasional redirects and a reset in the middle.
    $display("[TB] randomized traffic");
    doReset();
    setCfg(70, 60, 4, 1, 3);
    applyStimulus(1500);
    doReset();
    setCfg(70, 60, 4, 1, 3);
    applyStimulus(1500);
    checkOutput("rand_progress", 32'(n_pops >= 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
